// File: rtl/xbar_pkg.sv
// ============================================================================
//  Package   : xbar_pkg
//  Purpose   : Shared crossbar R-channel types, response codes and ID decode.
//  Revision  : 1.0
// ============================================================================
`default_nettype none

package xbar_pkg;

    localparam int XBAR_ID_W      = 4;
    localparam int XBAR_DATA_W    = 32;
    localparam int XBAR_ID_MAX_W  = 64;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_EXOKAY = 2'b01;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    typedef struct packed {
        logic [XBAR_ID_W-1:0]   id;
        logic [XBAR_DATA_W-1:0] data;
        logic [1:0]             resp;
        logic                   last;
    } r_beat_t;

    // Destination master lives in the top mdw bits of an id_w-bit ID.
    function automatic logic [XBAR_ID_MAX_W-1:0] dest_of(
        input logic [XBAR_ID_MAX_W-1:0] id,
        input int                       id_w,
        input int                       mdw
    );
        logic [XBAR_ID_MAX_W-1:0] mask;
        mask = (XBAR_ID_MAX_W'(1) << mdw) - XBAR_ID_MAX_W'(1);
        return (id >> (id_w - mdw)) & mask;
    endfunction

endpackage

`default_nettype wire

// File: rtl/return_fifo_storage.sv
// ============================================================================
//  Module    : return_fifo_storage
//  Purpose   : DEPTH x W register file, one write port, one async read port.
//  Revision  : 1.0
// ============================================================================
`default_nettype none

module return_fifo_storage #(
    parameter  int DEPTH = 4,
    parameter  int W     = 39,
    localparam int PW    = $clog2(DEPTH)
) (
    input  logic          ACLK,
    input  logic          ARESETn,
    input  logic          wr_en,
    input  logic [PW-1:0] wr_addr,
    input  logic [W-1:0]  wr_data,
    input  logic [PW-1:0] rd_addr,
    output logic [W-1:0]  rd_data
);

    logic [W-1:0] mem_q [DEPTH];
    logic [W-1:0] mem_d [DEPTH];

    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            mem_d[i] = mem_q[i];
        end
        if (wr_en) begin
            mem_d[wr_addr] = wr_data;
        end
    end

    // Clearing contents keeps the head fields at zero after any reset.
    always_ff @(posedge ACLK) begin
        for (int i = 0; i < DEPTH; i++) begin
            if (!ARESETn) begin
                mem_q[i] <= '0;
            end else begin
                mem_q[i] <= mem_d[i];
            end
        end
    end

    assign rd_data = mem_q[rd_addr];

endmodule

`default_nettype wire

// File: rtl/slave_return_fifo.sv
// ============================================================================
//  Module    : slave_return_fifo
//  Purpose   : Per-slave R-channel return buffer with destination decode.
//              Optional level/almost_full outputs under RETURN_FIFO_LEVEL_EN.
//  Revision  : 1.0
// ============================================================================
`default_nettype none

module slave_return_fifo
    import xbar_pkg::*;
#(
    parameter  int masters = 2,
    parameter  int DEPTH   = 4,
    parameter  int ID_W    = 4,
    parameter  int DATA_W  = 32,
    localparam int MDW     = $clog2(masters),
    localparam int PW      = $clog2(DEPTH)
) (
    input  logic              ACLK,
    input  logic              ARESETn,
    input  logic              s_rvalid,
    output logic              s_rready,
    input  logic [ID_W-1:0]   s_rid,
    input  logic [DATA_W-1:0] s_rdata,
    input  logic [1:0]        s_rresp,
    input  logic              s_rlast,
    output logic              fifo_empty,
    output logic [MDW-1:0]    fifo_master_dest,
    output logic [ID_W-1:0]   head_id,
    output logic [DATA_W-1:0] head_data,
    output logic [1:0]        head_resp,
    output logic              head_last,
    input  logic [masters-1:0] pop_vec
`ifdef RETURN_FIFO_LEVEL_EN
    ,
    output logic [PW:0]       level,
    output logic              almost_full
`endif
);

    localparam int PTR_W  = PW + 1;
    localparam int BEAT_W = ID_W + DATA_W + 3;

    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic              s_rready_q, s_rready_d;
    logic              push, pop, full_next;
    logic [BEAT_W-1:0] head_beat;

    assign fifo_empty = (wr_ptr_q == rd_ptr_q);
    assign push       = s_rvalid & s_rready_q;
    assign pop        = (|pop_vec) & ~fifo_empty;

    always_comb begin
        wr_ptr_d   = wr_ptr_q + PTR_W'(push);
        rd_ptr_d   = rd_ptr_q + PTR_W'(pop);
        // Full when indices match but the wrap bits differ.
        full_next  = (wr_ptr_d[PW] != rd_ptr_d[PW]) &&
                     (wr_ptr_d[PW-1:0] == rd_ptr_d[PW-1:0]);
        s_rready_d = ~full_next;
    end

    always_ff @(posedge ACLK) begin
        if (!ARESETn) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            s_rready_q <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            s_rready_q <= s_rready_d;
        end
    end

    assign s_rready = s_rready_q;

    return_fifo_storage #(
        .DEPTH (DEPTH),
        .W     (BEAT_W)
    ) u_storage (
        .ACLK    (ACLK),
        .ARESETn (ARESETn),
        .wr_en   (push),
        .wr_addr (wr_ptr_q[PW-1:0]),
        .wr_data ({s_rid, s_rdata, s_rresp, s_rlast}),
        .rd_addr (rd_ptr_q[PW-1:0]),
        .rd_data (head_beat)
    );

    assign {head_id, head_data, head_resp, head_last} = head_beat;
    assign fifo_master_dest = MDW'(dest_of(XBAR_ID_MAX_W'(head_id), ID_W, MDW));

`ifdef RETURN_FIFO_LEVEL_EN
    logic [PTR_W-1:0] level_q, level_d;

    always_comb begin
        level_d = wr_ptr_d - rd_ptr_d;
    end

    always_ff @(posedge ACLK) begin
        if (!ARESETn) begin
            level_q <= '0;
        end else begin
            level_q <= level_d;
        end
    end

    assign level       = level_q;
    assign almost_full = (level_q >= PTR_W'(DEPTH - 1));
`endif

    // Only the master named by the head beat may drain it.
    a_pop_onehot : assert property (@(posedge ACLK) disable iff (!ARESETn)
        !fifo_empty |-> ((pop_vec == '0) ||
                         (pop_vec == (masters'(1) << fifo_master_dest))));

endmodule

`default_nettype wire

// File: tb/tb_slave_return_fifo.sv
// ============================================================================
//  Module    : tb_slave_return_fifo
//  Purpose   : Randomised self-checking bench for slave_return_fifo against a
//              queue model; level checks active under RETURN_FIFO_LEVEL_EN.
//  Revision  : 1.0
// ============================================================================
`default_nettype none

module tb_slave_return_fifo;
    import xbar_pkg::*;

    localparam int MASTERS = 2;
    localparam int DEPTH   = 4;
    localparam int ID_W    = 4;
    localparam int DATA_W  = 32;
    localparam int MDW     = 1;
    localparam int PW      = 2;

    logic              ACLK    = 1'b0;
    logic              ARESETn = 1'b0;
    logic              s_rvalid = 1'b0;
    logic              s_rready;
    logic [ID_W-1:0]   s_rid   = '0;
    logic [DATA_W-1:0] s_rdata = '0;
    logic [1:0]        s_rresp = '0;
    logic              s_rlast = 1'b0;
    logic              fifo_empty;
    logic [MDW-1:0]    fifo_master_dest;
    logic [ID_W-1:0]   head_id;
    logic [DATA_W-1:0] head_data;
    logic [1:0]        head_resp;
    logic              head_last;
    logic [MASTERS-1:0] pop_vec = '0;
`ifdef RETURN_FIFO_LEVEL_EN
    logic [PW:0]       level;
    logic              almost_full;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    r_beat_t exp_q[$];
    bit      exp_rready = 1'b0;

    always #5 ACLK = ~ACLK;

    slave_return_fifo #(
        .masters (MASTERS),
        .DEPTH   (DEPTH),
        .ID_W    (ID_W),
        .DATA_W  (DATA_W)
    ) dut (
        .ACLK             (ACLK),
        .ARESETn          (ARESETn),
        .s_rvalid         (s_rvalid),
        .s_rready         (s_rready),
        .s_rid            (s_rid),
        .s_rdata          (s_rdata),
        .s_rresp          (s_rresp),
        .s_rlast          (s_rlast),
        .fifo_empty       (fifo_empty),
        .fifo_master_dest (fifo_master_dest),
        .head_id          (head_id),
        .head_data        (head_data),
        .head_resp        (head_resp),
        .head_last        (head_last),
        .pop_vec          (pop_vec)
`ifdef RETURN_FIFO_LEVEL_EN
        ,
        .level            (level),
        .almost_full      (almost_full)
`endif
    );

    function automatic r_beat_t rand_beat();
        r_beat_t b;
        b.id   = ID_W'($urandom);
        b.data = $urandom;
        b.resp = 2'($urandom);
        b.last = 1'($urandom);
        return b;
    endfunction

    function automatic int model_dest(input r_beat_t b);
        return int'(b.id) >> (ID_W - MDW);
    endfunction

    // Legal pop request for the current model head, or none when empty.
    function automatic logic [MASTERS-1:0] head_pv();
        if (exp_q.size() == 0) return '0;
        return MASTERS'(1) << model_dest(exp_q[0]);
    endfunction

    // One clock: drive inputs, advance the model at the edge, settle.
    task automatic step(input bit v, input r_beat_t b, input logic [MASTERS-1:0] pv);
        bit do_push, do_pop;
        s_rvalid = v;
        s_rid    = b.id;
        s_rdata  = b.data;
        s_rresp  = b.resp;
        s_rlast  = b.last;
        pop_vec  = pv;
        @(posedge ACLK);
        if (!ARESETn) begin
            exp_q.delete();
            exp_rready = 1'b0;
        end else begin
            do_push = v && exp_rready;
            do_pop  = (pv != '0) && (exp_q.size() != 0);
            if (do_pop)  void'(exp_q.pop_front());
            if (do_push) exp_q.push_back(b);
            exp_rready = (exp_q.size() < DEPTH);
        end
        #1;
        s_rvalid = 1'b0;
        pop_vec  = '0;
    endtask

    task automatic test_reset();
        ARESETn = 1'b0;
        step(0, rand_beat(), '0);
        step(0, rand_beat(), '0);
        n_checks++;
        if (fifo_empty !== 1'b1) begin
            n_fail++; $display("FAIL reset_empty: got %b want 1", fifo_empty);
        end
        n_checks++;
        if (s_rready !== 1'b0) begin
            n_fail++; $display("FAIL reset_rready: got %b want 0", s_rready);
        end
        n_checks++;
        if ({head_id, head_data, head_resp, head_last, fifo_master_dest} !== '0) begin
            n_fail++; $display("FAIL reset_head: got id=%h data=%h resp=%h last=%b dest=%h want all 0",
                               head_id, head_data, head_resp, head_last, fifo_master_dest);
        end
        ARESETn = 1'b1;
        step(0, rand_beat(), '0);
        n_checks++;
        if (s_rready !== 1'b1) begin
            n_fail++; $display("FAIL reset_release_rready: got %b want 1", s_rready);
        end
    endtask

    task automatic test_single();
        r_beat_t b;
        b      = rand_beat();
        b.id   = 4'b1010;
        step(1, b, '0);
        n_checks++;
        if (fifo_empty !== 1'b0) begin
            n_fail++; $display("FAIL single_empty: got %b want 0", fifo_empty);
        end
        n_checks++;
        if (fifo_master_dest !== 1'b1) begin
            n_fail++; $display("FAIL single_dest: got %h want 1", fifo_master_dest);
        end
        n_checks++;
        if ({head_id, head_data, head_resp, head_last} !== b) begin
            n_fail++; $display("FAIL single_head: got id=%h data=%h want id=%h data=%h",
                               head_id, head_data, b.id, b.data);
        end
        step(0, rand_beat(), 2'b10);
        n_checks++;
        if (fifo_empty !== 1'b1) begin
            n_fail++; $display("FAIL single_pop_empty: got %b want 1", fifo_empty);
        end
    endtask

    task automatic test_fill();
        r_beat_t b5;
        for (int i = 0; i < DEPTH; i++) begin
            step(1, rand_beat(), '0);
            n_checks++;
            if (s_rready !== exp_rready) begin
                n_fail++; $display("FAIL fill_rready[%0d]: got %b want %b", i, s_rready, exp_rready);
            end
        end
        n_checks++;
        if (s_rready !== 1'b0) begin
            n_fail++; $display("FAIL fill_full_rready: got %b want 0", s_rready);
        end
        b5 = rand_beat();
        step(1, b5, '0);
        n_checks++;
        if (s_rready !== 1'b0 || {head_id, head_data, head_resp, head_last} !== exp_q[0]) begin
            n_fail++; $display("FAIL fill_stall: rready=%b head=%h want rready=0 head=%h",
                               s_rready, {head_id, head_data, head_resp, head_last}, exp_q[0]);
        end
        step(1, b5, head_pv());
        n_checks++;
        if (s_rready !== 1'b1) begin
            n_fail++; $display("FAIL fill_reopen_rready: got %b want 1", s_rready);
        end
        step(1, b5, '0);
        n_checks++;
        if (s_rready !== 1'b0) begin
            n_fail++; $display("FAIL fill_refull_rready: got %b want 0", s_rready);
        end
        for (int i = 0; i < DEPTH + 1 && exp_q.size() != 0; i++) begin
            n_checks++;
            if ({head_id, head_data, head_resp, head_last} !== exp_q[0]) begin
                n_fail++; $display("FAIL fill_order[%0d]: got %h want %h", i,
                                   {head_id, head_data, head_resp, head_last}, exp_q[0]);
            end
            step(0, rand_beat(), head_pv());
        end
        n_checks++;
        if (fifo_empty !== 1'b1) begin
            n_fail++; $display("FAIL fill_drained: got %b want 1", fifo_empty);
        end
    endtask

    task automatic test_stream();
        step(1, rand_beat(), '0);
        step(1, rand_beat(), '0);
        for (int i = 0; i < 20; i++) begin
            step(1, rand_beat(), head_pv());
            n_checks++;
            if (fifo_empty !== 1'b0 || s_rready !== 1'b1 ||
                {head_id, head_data, head_resp, head_last} !== exp_q[0] ||
                exp_q.size() != 2) begin
                n_fail++; $display("FAIL stream[%0d]: empty=%b rready=%b head=%h want empty=0 rready=1 head=%h",
                                   i, fifo_empty, s_rready, {head_id, head_data, head_resp, head_last}, exp_q[0]);
            end
`ifdef RETURN_FIFO_LEVEL_EN
            n_checks++;
            if (level !== 3'd2) begin
                n_fail++; $display("FAIL stream_level[%0d]: got %0d want 2", i, level);
            end
`endif
        end
        for (int i = 0; i < DEPTH && exp_q.size() != 0; i++) begin
            n_checks++;
            if ({head_id, head_data, head_resp, head_last} !== exp_q[0]) begin
                n_fail++; $display("FAIL stream_drain[%0d]: got %h want %h", i,
                                   {head_id, head_data, head_resp, head_last}, exp_q[0]);
            end
            step(0, rand_beat(), head_pv());
        end
    endtask

    task automatic test_pop_empty();
        r_beat_t b;
        step(0, rand_beat(), 2'b01);
        step(0, rand_beat(), 2'b10);
        n_checks++;
        if (fifo_empty !== 1'b1 || s_rready !== 1'b1) begin
            n_fail++; $display("FAIL pop_empty: empty=%b rready=%b want 1 1", fifo_empty, s_rready);
        end
        b = rand_beat();
        step(1, b, '0);
        n_checks++;
        if (fifo_empty !== 1'b0 || {head_id, head_data, head_resp, head_last} !== b) begin
            n_fail++; $display("FAIL pop_empty_next: empty=%b head=%h want 0 %h",
                               fifo_empty, {head_id, head_data, head_resp, head_last}, b);
        end
        step(0, rand_beat(), head_pv());
    endtask

    task automatic test_reset_mid();
        r_beat_t b;
        for (int i = 0; i < 3; i++) step(1, rand_beat(), '0);
        ARESETn = 1'b0;
        step(1, rand_beat(), '0);
        n_checks++;
        if (fifo_empty !== 1'b1 || s_rready !== 1'b0) begin
            n_fail++; $display("FAIL mid_reset: empty=%b rready=%b want 1 0", fifo_empty, s_rready);
        end
        ARESETn = 1'b1;
        step(0, rand_beat(), '0);
        n_checks++;
        if (fifo_empty !== 1'b1 || s_rready !== 1'b1) begin
            n_fail++; $display("FAIL mid_release: empty=%b rready=%b want 1 1", fifo_empty, s_rready);
        end
        b = rand_beat();
        step(1, b, '0);
        n_checks++;
        if ({head_id, head_data, head_resp, head_last} !== b) begin
            n_fail++; $display("FAIL mid_stale: head=%h want %h", {head_id, head_data, head_resp, head_last}, b);
        end
        step(0, rand_beat(), head_pv());
        n_checks++;
        if (fifo_empty !== 1'b1) begin
            n_fail++; $display("FAIL mid_drain: empty=%b want 1", fifo_empty);
        end
    endtask

`ifdef RETURN_FIFO_LEVEL_EN
    task automatic test_level();
        for (int i = 0; i < 3; i++) step(1, rand_beat(), '0);
        n_checks++;
        if (level !== 3'd3 || almost_full !== 1'b1) begin
            n_fail++; $display("FAIL level_3: level=%0d af=%b want 3 1", level, almost_full);
        end
        step(0, rand_beat(), head_pv());
        n_checks++;
        if (level !== 3'd2 || almost_full !== 1'b0) begin
            n_fail++; $display("FAIL level_2: level=%0d af=%b want 2 0", level, almost_full);
        end
        for (int i = 0; i < DEPTH && exp_q.size() != 0; i++) step(0, rand_beat(), head_pv());
    endtask
`endif

    task automatic test_random();
        for (int i = 0; i < 300; i++) begin
            step(1'($urandom_range(0, 1)), rand_beat(),
                 ($urandom_range(0, 2) != 0) ? head_pv() : '0);
            n_checks++;
            if (fifo_empty !== (exp_q.size() == 0) || s_rready !== exp_rready) begin
                n_fail++; $display("FAIL rand_flags[%0d]: empty=%b rready=%b want %b %b",
                                   i, fifo_empty, s_rready, exp_q.size() == 0, exp_rready);
            end
            if (exp_q.size() != 0) begin
                n_checks++;
                if ({head_id, head_data, head_resp, head_last} !== exp_q[0] ||
                    int'(fifo_master_dest) != model_dest(exp_q[0])) begin
                    n_fail++; $display("FAIL rand_head[%0d]: head=%h dest=%0d want %h %0d", i,
                                       {head_id, head_data, head_resp, head_last}, fifo_master_dest,
                                       exp_q[0], model_dest(exp_q[0]));
                end
            end
`ifdef RETURN_FIFO_LEVEL_EN
            n_checks++;
            if (int'(level) != exp_q.size() || almost_full !== (exp_q.size() >= DEPTH - 1)) begin
                n_fail++; $display("FAIL rand_level[%0d]: level=%0d af=%b want %0d", i,
                                   level, almost_full, exp_q.size());
            end
`endif
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_fill();
        test_stream();
        test_pop_empty();
        test_reset_mid();
`ifdef RETURN_FIFO_LEVEL_EN
        test_level();
`endif
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
